alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  16-bit registered ALU for the CR16-style datapath; executes register and
//  immediate arithmetic/logic/shift ops selected by an 8-bit opcode.
//  Result and 5 status flags are captured on the clock edge and feed the
//  register file write-back and the PSR/branch logic.
//  Immediate operands arrive on B already extended by the decoder.
// PARAMETERS
//  WIDTH  16  datapath width; all arithmetic rules below assume 16.
// PORTS
//  clk     in   1   single clock; all state updates on rising edge.
//  reset   in   1   asynchronous, active-high reset.
//  A       in   16  first operand (Rdest value).
//  B       in   16  second operand (Rsrc value or extended immediate).
//  Opcode  in   8   {op[7:4], ext[3:0]}; immediate ops decode on op only.
//  C       out  16  registered result.
//  Flags   out  5   registered {N, Z, F, L, C} = Flags[4:0].
// BEHAVIOUR
//  - Reset: async reset drives C=16'h0000, Flags=5'b00000 immediately.
//  - Latency 1: inputs sampled at posedge clk; C/Flags valid after that edge.
//  - No handshake; a new op may be issued every cycle.
//  - Opcode map (R-type op=0000, ext listed; I-type by op[7:4]):
//    ADD 0000_0101 / ADDI 0101: C=A+B; Flags.C=carry out, F=signed ovf.
//    ADDU 0000_0110 / ADDUI 0110: C=A+B; C flag=carry out only.
//    SUB 0000_1001 / SUBI 1001: C=A-B; C flag=borrow (A<B unsigned),
//      F=signed ovf.
//    CMP 0000_1011 / CMPI 1011: C register holds previous value;
//      Z=(A==B), N=($signed(A)<$signed(B)), L=(A<B unsigned).
//    AND 0000_0001 / ANDI 0001, OR 0000_0010 / ORI 0010,
//      XOR 0000_0011 / XORI 0011: bitwise; no flags change.
//    MOV 0000_1101 / MOVI 1101: C=B; no flags change.
//    LSH 1000_0100 / LSHI 1000_000x: s=$signed(B); s>=0 -> A<<s[3:0];
//      s<0 -> A>> (-s)[3:0] logical; |s|>15 gives 0.
//    ASHU 1000_0110: as LSH but right shift is arithmetic (sign fill).
//    LUI 1111: C={B[7:0], 8'h00}; no flags change.
//  - Flags not listed for an op hold their previous value.
//  - Undefined opcode: C=16'h0000, all flags hold.
//  - Overflow: F=1 when operand signs match (ADD) or differ (SUB) and
//    result sign differs from A.
//  - Wrap-around: results are modulo 2^16; carry/borrow is bit 16.
//  - Reset asserted mid-operation wins over any clock edge.
// TESTING
//  1. reset=1 with A=16'h1234,B=16'h1,ADD -> C=0, Flags=0 without clock.
//  2. ADD A=16'h7FFF,B=16'h0001 -> C=16'h8000, F=1, C flag=0.
//  3. ADD A=16'hFFFF,B=16'h0001 -> C=16'h0000, C flag=1, F=0;
//     then ADDI same operands -> identical result.
//  4. SUB A=5,B=7 -> C=16'hFFFE, C flag=1, F=0.
//  5. CMP A=3,B=16'hFFFF -> C unchanged, Z=0, N=0, L=1; CMP A=B=9 -> Z=1.
//  6. LSH A=1,B=4 -> 16'h0010; LSH A=16'h8000,B=16'hFFFC -> 16'h0800;
//     ASHU A=16'h8000,B=16'hFFFC -> 16'hF800.
//  Random: 50 ADD and 50 ADDI vectors checked vs model (signed display).

Source files
------------

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the decode stage and the ALU.
// The master drives operands and opcode; the slave returns the registered
// result and status flags.
interface alu_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [7:0]       Opcode;
  logic [WIDTH-1:0] C;
  logic [4:0]       Flags;

  modport master (
    output A,
    output B,
    output Opcode,
    input  C,
    input  Flags
  );

  modport slave (
    input  A,
    input  B,
    input  Opcode,
    output C,
    output Flags
  );
endinterface

// File: rtl/alu.sv
// 16-bit registered ALU for the CR16-style datapath.
// One-cycle latency: operands and opcode are sampled on the rising edge and
// the result C plus flags {N, Z, F, L, C} are held in registers.
// Flags an operation does not define keep their previous value.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);

  // Operation classes after opcode decode
  localparam logic [3:0] K_UND  = 4'd0;
  localparam logic [3:0] K_ADD  = 4'd1;
  localparam logic [3:0] K_ADDU = 4'd2;
  localparam logic [3:0] K_SUB  = 4'd3;
  localparam logic [3:0] K_CMP  = 4'd4;
  localparam logic [3:0] K_AND  = 4'd5;
  localparam logic [3:0] K_OR   = 4'd6;
  localparam logic [3:0] K_XOR  = 4'd7;
  localparam logic [3:0] K_MOV  = 4'd8;
  localparam logic [3:0] K_LSH  = 4'd9;
  localparam logic [3:0] K_ASHU = 4'd10;
  localparam logic [3:0] K_LUI  = 4'd11;

  // Flag bit positions inside the Flags vector
  localparam int FN = 4;
  localparam int FZ = 3;
  localparam int FF = 2;
  localparam int FL = 1;
  localparam int FC = 0;

  logic [WIDTH-1:0] c_r;
  logic [4:0]       flags_r;
  logic [WIDTH-1:0] c_next_s;
  logic [4:0]       flags_next_s;
  logic [3:0]       kind_s;
  logic [3:0]       op_s;
  logic [3:0]       ext_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             add_ovf_s;
  logic             sub_ovf_s;

  // R-type ext codes and I-type op codes share one encoding for the
  // arithmetic/logic/move group, so both decode through this table.
  function automatic logic [3:0] map_f(input logic [3:0] code);
    logic [3:0] k;
    case (code)
      4'b0101: k = K_ADD;
      4'b0110: k = K_ADDU;
      4'b1001: k = K_SUB;
      4'b1011: k = K_CMP;
      4'b0001: k = K_AND;
      4'b0010: k = K_OR;
      4'b0011: k = K_XOR;
      4'b1101: k = K_MOV;
      default: k = K_UND;
    endcase
    return k;
  endfunction

  // Signed shift: B >= 0 shifts left, B < 0 shifts right by -B.
  // The magnitude is 17 bits so that -32768 is represented correctly;
  // any magnitude above 15 yields zero.
  function automatic logic [15:0] shift_f(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic        arith);
    logic [16:0] mag;
    logic [15:0] res;
    if (b[15]) begin
      mag = 17'h10000 - {1'b0, b};
    end else begin
      mag = {1'b0, b};
    end
    if (mag > 17'd15) begin
      res = 16'h0000;
    end else if (b[15]) begin
      res = arith ? $unsigned($signed(a) >>> mag[3:0]) : (a >> mag[3:0]);
    end else begin
      res = a << mag[3:0];
    end
    return res;
  endfunction

  assign op_s   = bus.Opcode[7:4];
  assign ext_s  = bus.Opcode[3:0];

  // Carry and borrow both land in bit WIDTH of the zero-extended result
  assign sum_s     = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff_s    = {1'b0, bus.A} - {1'b0, bus.B};
  assign add_ovf_s = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                     (sum_s[WIDTH-1] != bus.A[WIDTH-1]);
  assign sub_ovf_s = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                     (diff_s[WIDTH-1] != bus.A[WIDTH-1]);

  // Decode the 8-bit opcode into an operation class
  always_comb begin
    kind_s = K_UND;
    case (op_s)
      4'b0000: kind_s = map_f(ext_s);
      4'b1000: begin
        case (ext_s)
          4'b0100: kind_s = K_LSH;
          4'b0110: kind_s = K_ASHU;
          4'b0000: kind_s = K_LSH;
          4'b0001: kind_s = K_LSH;
          default: kind_s = K_UND;
        endcase
      end
      4'b1111: kind_s = K_LUI;
      default: kind_s = map_f(op_s);
    endcase
  end

  // Compute next result and flags; untouched flags and CMP's result hold
  always_comb begin
    c_next_s     = c_r;
    flags_next_s = flags_r;
    case (kind_s)
      K_ADD: begin
        c_next_s         = sum_s[WIDTH-1:0];
        flags_next_s[FC] = sum_s[WIDTH];
        flags_next_s[FF] = add_ovf_s;
      end
      K_ADDU: begin
        c_next_s         = sum_s[WIDTH-1:0];
        flags_next_s[FC] = sum_s[WIDTH];
      end
      K_SUB: begin
        c_next_s         = diff_s[WIDTH-1:0];
        flags_next_s[FC] = diff_s[WIDTH];
        flags_next_s[FF] = sub_ovf_s;
      end
      K_CMP: begin
        flags_next_s[FZ] = (bus.A == bus.B);
        flags_next_s[FN] = ($signed(bus.A) < $signed(bus.B));
        flags_next_s[FL] = (bus.A < bus.B);
      end
      K_AND:   c_next_s = bus.A & bus.B;
      K_OR:    c_next_s = bus.A | bus.B;
      K_XOR:   c_next_s = bus.A ^ bus.B;
      K_MOV:   c_next_s = bus.B;
      K_LSH:   c_next_s = shift_f(bus.A, bus.B, 1'b0);
      K_ASHU:  c_next_s = shift_f(bus.A, bus.B, 1'b1);
      K_LUI:   c_next_s = {bus.B[7:0], 8'h00};
      default: c_next_s = 16'h0000;
    endcase
  end

  // Result and flag registers; reset clears both asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_r     <= 16'h0000;
      flags_r <= 5'b00000;
    end else begin
      c_r     <= c_next_s;
      flags_r <= flags_next_s;
    end
  end

  assign bus.C     = c_r;
  assign bus.Flags = flags_r;

endmodule

// File: tb/tb_alu.sv
// Directed and random checks for the registered 16-bit ALU.
// Expected values are hand-computed constants; the random ADD/ADDI phase
// uses a small arithmetic model of sum, carry and signed overflow.
module tb_alu;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation between edges and sample just after the next edge
  task automatic apply(input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] op);
    @(negedge clk);
    bus.A      = a;
    bus.B      = b;
    bus.Opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] ec,
                     input logic [4:0] ef);
    checks++;
    assert (bus.C === ec) else begin
      errors++;
      $error("FAIL %s C: observed %h expected %h", tag, bus.C, ec);
    end
    checks++;
    assert (bus.Flags === ef) else begin
      errors++;
      $error("FAIL %s Flags: observed %b expected %b", tag, bus.Flags, ef);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [7:0]  rop;
    logic [16:0] s17;
    logic [4:0]  mf;

    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus.A      = 16'h1234;
    bus.B      = 16'h0001;
    bus.Opcode = 8'h05;
    #1;
    chk("reset_no_clock", 16'h0000, 5'b00000);

    @(negedge clk);
    reset = 1'b0;

    // Flags order {N, Z, F, L, C}
    apply(16'h7FFF, 16'h0001, 8'h05); chk("add_ovf",      16'h8000, 5'b00100);
    apply(16'hFFFF, 16'h0001, 8'h05); chk("add_carry",    16'h0000, 5'b00001);
    apply(16'hFFFF, 16'h0001, 8'h50); chk("addi_carry",   16'h0000, 5'b00001);
    apply(16'h8000, 16'h0001, 8'h09); chk("sub_ovf",      16'h7FFF, 5'b00100);
    apply(16'h0005, 16'h0007, 8'h09); chk("sub_borrow",   16'hFFFE, 5'b00001);
    apply(16'h0003, 16'hFFFF, 8'h0B); chk("cmp_lt_u",     16'hFFFE, 5'b00011);
    apply(16'h0009, 16'h0009, 8'h0B); chk("cmp_eq",       16'hFFFE, 5'b01001);
    apply(16'hFFFF, 16'h0001, 8'hB3); chk("cmpi_neg",     16'hFFFE, 5'b10001);
    apply(16'hF0F0, 16'hFF00, 8'h01); chk("and",          16'hF000, 5'b10001);
    apply(16'hF0F0, 16'h0F0F, 8'h2A); chk("ori",          16'hFFFF, 5'b10001);
    apply(16'hAAAA, 16'hFFFF, 8'h03); chk("xor",          16'h5555, 5'b10001);
    apply(16'h0000, 16'h1357, 8'h0D); chk("mov",          16'h1357, 5'b10001);
    apply(16'h0000, 16'h00AB, 8'hF0); chk("lui",          16'hAB00, 5'b10001);
    apply(16'h0001, 16'h0002, 8'h06); chk("addu",         16'h0003, 5'b10000);
    apply(16'h0001, 16'h0004, 8'h84); chk("lsh_left",     16'h0010, 5'b10000);
    apply(16'h8000, 16'hFFFC, 8'h84); chk("lsh_right",    16'h0800, 5'b10000);
    apply(16'h8000, 16'hFFFC, 8'h86); chk("ashu_right",   16'hF800, 5'b10000);
    apply(16'h0003, 16'h0002, 8'h81); chk("lshi",         16'h000C, 5'b10000);
    apply(16'h0001, 16'h0010, 8'h84); chk("lsh_over15",   16'h0000, 5'b10000);
    apply(16'h0000, 16'h1234, 8'hD7); chk("movi",         16'h1234, 5'b10000);
    apply(16'h1111, 16'h2222, 8'h00); chk("undef_r",      16'h0000, 5'b10000);
    apply(16'h0000, 16'h4321, 8'h0D); chk("mov2",         16'h4321, 5'b10000);
    apply(16'h1111, 16'h2222, 8'h40); chk("undef_i",      16'h0000, 5'b10000);
    apply(16'h0000, 16'h5A5A, 8'h0D); chk("mov_pre_rst",  16'h5A5A, 5'b10000);

    // Reset raised between edges must clear outputs without a clock edge
    #2;
    reset = 1'b1;
    #1;
    chk("reset_async", 16'h0000, 5'b00000);
    @(negedge clk);
    reset = 1'b0;

    // Random ADD / ADDI: only F and C flags move, N/Z/L stay cleared
    mf = 5'b00000;
    for (int i = 0; i < 100; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = (i < 50) ? 8'h05 : {4'b0101, 4'($urandom)};
      s17 = {1'b0, ra} + {1'b0, rb};
      mf[0] = s17[16];
      mf[2] = (ra[15] == rb[15]) && (s17[15] != ra[15]);
      apply(ra, rb, rop);
      checks++;
      assert ((bus.C === s17[15:0]) && (bus.Flags === mf)) else begin
        errors++;
        $error("FAIL rand_add op=%h A=%0d B=%0d: observed C=%0d F=%b expected C=%0d F=%b",
               rop, $signed(ra), $signed(rb), $signed(bus.C), bus.Flags,
               $signed(s17[15:0]), mf);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
